// File: rtl/imem_loader.sv
// Streams 64-bit host words into instruction memory one byte per clock.
// The processor is held off with busy while an image is being loaded.
module imem_loader #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] base_addr,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  input  logic [3:0]  in_nbytes,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        load_error,
  output logic [63:0] bytes_written
);

  // state  | meaning
  // S_IDLE | out of reset, no load started
  // S_WAIT | load active, waiting for the next host word
  // S_EMIT | writing the captured word, one byte per cycle
  // S_DONE | last word written, image complete
  // S_ERR  | word rejected, load aborted
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_EMIT, S_DONE, S_ERR} state_t;

  localparam logic [64:0] MEM_LIM = 65'(MEM_BYTES);

  state_t      state_q, state_d;
  logic [63:0] addr_ptr_q, addr_ptr_d;
  logic [63:0] bytes_written_q, bytes_written_d;
  logic [63:0] data_q, data_d;
  logic [3:0]  nbytes_q, nbytes_d;
  logic        last_q, last_d;
  logic [2:0]  idx_q, idx_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        load_error_q, load_error_d;

  logic        idle_like;
  logic        accept;
  logic        bad_n;
  logic        ovf;
  logic [64:0] end_addr;
  logic        last_byte;
  logic [2:0]  idx_inc;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
  assign accept    = (state_q == S_WAIT) && in_valid;
  assign bad_n     = (in_nbytes == 4'd0) || (in_nbytes > 4'd8);
  // 65-bit sum so a base near the top of the address space cannot wrap past the check
  assign end_addr  = {1'b0, addr_ptr_q} + {61'd0, in_nbytes};
  assign ovf       = end_addr > MEM_LIM;
  assign last_byte = ({1'b0, idx_q} == (nbytes_q - 4'd1));
  assign idx_inc   = idx_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      addr_ptr_q      <= '0;
      bytes_written_q <= '0;
      data_q          <= '0;
      nbytes_q        <= '0;
      last_q          <= 1'b0;
      idx_q           <= '0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      load_error_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_ptr_q      <= addr_ptr_d;
      bytes_written_q <= bytes_written_d;
      data_q          <= data_d;
      nbytes_q        <= nbytes_d;
      last_q          <= last_d;
      idx_q           <= idx_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      load_error_q    <= load_error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_WAIT;
      S_WAIT: begin
        if (in_valid) begin
          if (bad_n || ovf) state_d = S_ERR;
          else              state_d = S_EMIT;
        end
      end
      S_EMIT: if (last_byte) state_d = last_q ? S_DONE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  // Write strobe/address/data are registered, so the first byte is launched
  // on the acceptance edge and each EMIT cycle launches the following byte.
  always_comb begin
    addr_ptr_d      = addr_ptr_q;
    bytes_written_d = bytes_written_q;
    data_d          = data_q;
    nbytes_d        = nbytes_q;
    last_d          = last_q;
    idx_d           = idx_q;
    mem_we_d        = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;

    if (idle_like && start) begin
      addr_ptr_d      = base_addr;
      bytes_written_d = '0;
    end

    if (accept) begin
      data_d   = in_data;
      nbytes_d = in_nbytes;
      last_d   = in_last;
      idx_d    = '0;
      if (state_d == S_EMIT) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_ptr_q;
        mem_wdata_d = in_data[7:0];
      end
    end

    if (state_q == S_EMIT) begin
      addr_ptr_d      = addr_ptr_q + 64'd1;
      bytes_written_d = bytes_written_q + 64'd1;
      if (!last_byte) begin
        idx_d       = idx_inc;
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_ptr_q + 64'd1;
        mem_wdata_d = data_q[{idx_inc, 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    busy_d       = (state_d == S_WAIT) || (state_d == S_EMIT);
    done_d       = (state_d == S_DONE);
    load_error_d = (state_d == S_ERR);
  end

  assign in_ready      = (state_q == S_WAIT);
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign load_error    = load_error_q;
  assign bytes_written = bytes_written_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes a Y86-64 object image into instruction memory, one byte per clock, for the SEQ fetch stage to read back. A host or testbench streams 64-bit little-endian words through a valid/ready handshake; the block serialises each word into byte writes at consecutive addresses starting at a programmable base. It sits between the host-side program source and the instruction memory's byte write port, and holds the processor off while loading.

## Interface
- MEM_BYTES, 1024, instruction memory size in bytes; legal addresses 0..MEM_BYTES-1
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load at base_addr (ignored unless state is IDLE or DONE or ERR)
- base_addr  in  64  first byte address, sampled on start
- in_valid  in  1  word available
- in_data  in  64  word; byte i = in_data[8i+7:8i], byte 0 written first
- in_nbytes  in  4  number of valid bytes in word, legal 1..8
- in_last  in  1  word is the final one of the image
- in_ready  out  1  loader can accept a word
- mem_we  out  1  byte write strobe
- mem_addr  out  64  byte write address
- mem_wdata  out  8  byte write data
- busy  out  1  load in progress; fetch must not run
- done  out  1  image loaded without error
- load_error  out  1  load aborted
- bytes_written  out  64  count of bytes written in current/last load

## Operation
- States: IDLE, WAIT, EMIT, DONE, ERR.
- IDLE: in_ready=0, busy=0. start -> WAIT; addr_ptr<=base_addr; bytes_written<=0; done<=0; load_error<=0.
- DONE/ERR: same start behaviour as IDLE; otherwise hold.
- WAIT: in_ready=1, busy=1. On in_valid&&in_ready: capture in_data, in_nbytes, in_last; byte index<=0.
  - in_nbytes==0 or >8 -> ERR, nothing written.
  - addr_ptr+in_nbytes > MEM_BYTES (compute in 65 bits, no wrap) -> ERR, nothing written; partial words are never written.
  - else -> EMIT.
- EMIT: in_ready=0, busy=1. Each cycle: mem_we=1, mem_addr=addr_ptr, mem_wdata=captured byte[index]; addr_ptr+1, index+1, bytes_written+1. After byte in_nbytes-1: in_last -> DONE, else -> WAIT.
- DONE: done=1 held, busy=0. ERR: load_error=1 held, busy=0. Both cleared by next accepted start.
- start during WAIT or EMIT is ignored; the load continues unaffected.
- mem_we is never 1 outside EMIT; mem_addr/mem_wdata hold last values when mem_we=0.

## Timing
- All outputs registered except in_ready (decoded from state: 1 iff WAIT).
- Reset (asynchronous, immediate on rst_n=0): state IDLE; in_ready, mem_we, busy, done, load_error = 0; mem_addr, mem_wdata, bytes_written = 0. Reset mid-load abandons the load; already-written bytes remain in memory.
- start at edge t -> WAIT from t+1 (in_ready=1 that cycle).
- Word accepted at edge t -> first mem_we at t+1; n-byte word occupies n EMIT cycles; in_ready returns at t+n+1 (if not last). Throughput: n+1 cycles per n-byte word.
- Last byte of in_last word at cycle c -> done=1 from c+1.
- Error detected at acceptance edge t -> load_error=1 from t+1, no mem_we pulse.

## Test plan
- Reset then start, base_addr=0, two words 0x0000_0000_0030_F430 (nbytes=8) and 0x0000_0000_0000_0010 (nbytes=8, last) -> 16 writes, addr 0..15, bytes 30,F4,30,00,... ,10,00..; done=1 one cycle after 16th write; bytes_written=16.
- base_addr=100, one word 0xAABBCC nbytes=3 last -> writes CC@100, BB@101, AA@102; done=1; in_ready held 0 during EMIT.
- base_addr=1020 (MEM_BYTES=1024), word nbytes=8 -> no mem_we ever, load_error=1, done=0; new start clears load_error.
- in_nbytes=0 and in_nbytes=9 words -> each goes to ERR with no writes.
- rst_n pulled low in middle of EMIT at byte 3 -> mem_we, busy, bytes_written 0 immediately; state IDLE; subsequent start loads normally.
- start re-pulsed during EMIT and WAIT -> ignored; addresses continue incrementing from original base; in_valid held low in WAIT -> block waits indefinitely with busy=1.
